// File: rtl/vai_pkg.sv
// -----------------------------------------------------------------------------
// vai_pkg
// Shared definitions for the VAI Tx/Rx arbitration blocks.
//   VAI_N_REQ       default number of requesters (sub-AFUs + manager)
//   VAI_W_WIDTH     default width of a weight / credit counter
//   VAI_IDX_W       width of a requester index
//   VAI_MGR_IDX     requester index of the manager AFU (always the last one)
//   t_vai_weight    weight / credit value
//   t_vai_req_idx   binary requester index
//   t_vai_arb_state arbiter state encoding
// -----------------------------------------------------------------------------
package vai_pkg;

   localparam int VAI_N_REQ   = 9;
   localparam int VAI_W_WIDTH = 4;
   localparam int VAI_IDX_W   = $clog2(VAI_N_REQ);
   localparam int VAI_MGR_IDX = VAI_N_REQ - 1;

   localparam logic [15:0] VAI_REFILL_CNT_MAX = 16'hFFFF;

   typedef logic [VAI_W_WIDTH-1:0] t_vai_weight;
   typedef logic [VAI_IDX_W-1:0]   t_vai_req_idx;

   typedef enum logic {
      VAI_ST_ARB    = 1'b0,
      VAI_ST_REFILL = 1'b1
   } t_vai_arb_state;

endpackage

// File: rtl/vai_rr_pick.sv
// -----------------------------------------------------------------------------
// vai_rr_pick
// Combinational rotating-priority picker. Scans last_i+1, last_i+2, ...
// wrapping modulo N and selects the first set bit of elig_i.
//   elig_i    [N]   candidate vector
//   last_i    [IW]  index granted most recently (lowest priority this round)
//   onehot_o  [N]   one-hot selection, zero when nothing is eligible
//   idx_o     [IW]  binary index of the selection, zero when nothing is eligible
//   any_o           at least one candidate was found
// -----------------------------------------------------------------------------
module vai_rr_pick #(
   parameter int N  = 9,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  elig_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  onehot_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   int pos;

   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      any_o    = 1'b0;
      pos      = 0;
      // k = N visits last_i itself, so a sole candidate can win again.
      for (int k = 1; k <= N; k++) begin
         pos = int'(last_i) + k;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (!any_o && elig_i[pos[IW-1:0]]) begin
            any_o                 = 1'b1;
            onehot_o[pos[IW-1:0]] = 1'b1;
            idx_o                 = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/vai_tx_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// vai_tx_wrr_arbiter
// Weighted round-robin grant scheduler for one CCI-P Tx channel. Each requester
// holds a credit counter reloaded from its MMIO-programmed weight; a grant costs
// one credit. When every requester with pending work is out of credit, a single
// REFILL cycle reloads all counters. The manager AFU (last index) can bypass
// credits entirely when MGR_PRIORITY is set.
//   clk          clock
//   reset        synchronous active-high reset
//   req          per-requester head-entry-valid
//   up_almFull   upstream almost-full; suppresses new grants
//   wt_wr_en     weight write strobe
//   wt_wr_idx    requester index of the weight write
//   wt_wr_data   new weight (0 disables the requester)
//   grant        registered one-hot grant
//   grant_valid  OR of grant
//   grant_idx    binary index of grant, 0 when idle
//   refill_cnt   saturating count of REFILL cycles
// -----------------------------------------------------------------------------
module vai_tx_wrr_arbiter
   import vai_pkg::*;
#(
   parameter int N_REQ        = VAI_N_REQ,
   parameter int W_WIDTH      = VAI_W_WIDTH,
   parameter bit MGR_PRIORITY = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic                     up_almFull,
   input  logic                     wt_wr_en,
   input  logic [$clog2(N_REQ)-1:0] wt_wr_idx,
   input  logic [W_WIDTH-1:0]       wt_wr_data,
   output logic [N_REQ-1:0]         grant,
   output logic                     grant_valid,
   output logic [$clog2(N_REQ)-1:0] grant_idx,
   output logic [15:0]              refill_cnt
);

   localparam int IW  = $clog2(N_REQ);
   localparam int MGR = N_REQ - 1;

   t_vai_arb_state   state_q, state_d;
   logic [IW-1:0]    last_q, last_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             grant_valid_q, grant_valid_d;
   logic [IW-1:0]    grant_idx_q, grant_idx_d;
   logic [15:0]      refill_cnt_q, refill_cnt_d;

   logic [N_REQ-1:0] eligible;
   logic [N_REQ-1:0] pending;
   logic [N_REQ-1:0] dec;
   logic [N_REQ-1:0] pick_onehot;
   logic [IW-1:0]    pick_idx;
   logic             pick_any;
   logic             do_refill;
   logic             arb_grant;

   // Per-requester weight and credit storage. Out-of-range write indices
   // never match any gi, so they are dropped without extra logic.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
         logic [W_WIDTH-1:0] weight_q, weight_d;
         logic [W_WIDTH-1:0] credit_q, credit_d;
         logic [W_WIDTH-1:0] credit_n;
         logic               wr_hit;

         assign wr_hit       = wt_wr_en && (wt_wr_idx == IW'(gi));
         assign eligible[gi] = req[gi] && (credit_q != '0) && (weight_q != '0);
         assign pending[gi]  = req[gi] && (weight_q != '0);

         always_comb begin
            credit_n = credit_q;
            if (do_refill) begin
               credit_n = weight_q;
            end else if (dec[gi]) begin
               credit_n = credit_q - 1'b1;
            end
            weight_d = weight_q;
            credit_d = credit_n;
            // A lowered weight clamps credit already held, so a disabled
            // requester cannot spend leftover credit.
            if (wr_hit) begin
               weight_d = wt_wr_data;
               if (wt_wr_data < credit_n) begin
                  credit_d = wt_wr_data;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               weight_q <= W_WIDTH'(1);
               credit_q <= W_WIDTH'(1);
            end else begin
               weight_q <= weight_d;
               credit_q <= credit_d;
            end
         end
      end
   endgenerate

   vai_rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_pick (
      .elig_i   (eligible),
      .last_i   (last_q),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .any_o    (pick_any)
   );

   assign dec = arb_grant ? pick_onehot : '0;

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      grant_d       = '0;
      grant_valid_d = 1'b0;
      grant_idx_d   = '0;
      refill_cnt_d  = refill_cnt_q;
      do_refill     = 1'b0;
      arb_grant     = 1'b0;

      if (state_q == VAI_ST_REFILL) begin
         // Refill ignores up_almFull; it never issues a grant anyway.
         do_refill = 1'b1;
         if (refill_cnt_q != VAI_REFILL_CNT_MAX) begin
            refill_cnt_d = refill_cnt_q + 16'd1;
         end
         state_d = VAI_ST_ARB;
      end else if (!up_almFull) begin
         if (MGR_PRIORITY && req[MGR]) begin
            // Manager bypass leaves credits and the rotation pointer alone.
            grant_d[MGR]  = 1'b1;
            grant_valid_d = 1'b1;
            grant_idx_d   = IW'(MGR);
         end else if (pick_any) begin
            arb_grant     = 1'b1;
            grant_d       = pick_onehot;
            grant_valid_d = 1'b1;
            grant_idx_d   = pick_idx;
            last_d        = pick_idx;
         end else if (|pending) begin
            state_d = VAI_ST_REFILL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= VAI_ST_ARB;
         last_q        <= IW'(MGR);
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_idx_q   <= '0;
         refill_cnt_q  <= '0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         grant_idx_q   <= grant_idx_d;
         refill_cnt_q  <= refill_cnt_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_idx   = grant_idx_q;
   assign refill_cnt  = refill_cnt_q;

endmodule

// File: tb/tb_vai_tx_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vai_tx_wrr_arbiter
// Directed bench for vai_tx_wrr_arbiter. Each step predicts the outputs after
// the next clock edge with a behavioural model, queues the prediction, then
// pops it and compares it with the registered outputs. Directed checks with
// hand-derived constants cover the scenarios of interest.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vai_tx_wrr_arbiter;
   import vai_pkg::*;

   localparam int N  = VAI_N_REQ;
   localparam int IW = VAI_IDX_W;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req;
   logic              up_almFull;
   logic              wt_wr_en;
   logic [IW-1:0]     wt_wr_idx;
   logic [3:0]        wt_wr_data;
   logic [N-1:0]      grant;
   logic              grant_valid;
   logic [IW-1:0]     grant_idx;
   logic [15:0]       refill_cnt;

   always #5 clk = ~clk;

   vai_tx_wrr_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .up_almFull  (up_almFull),
      .wt_wr_en    (wt_wr_en),
      .wt_wr_idx   (wt_wr_idx),
      .wt_wr_data  (wt_wr_data),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx),
      .refill_cnt  (refill_cnt)
   );

   typedef struct packed {
      logic [N-1:0]  grant;
      logic          gv;
      logic [IW-1:0] idx;
      logic [15:0]   rc;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_step = 0;

   // Reference model state (value after the most recently predicted edge).
   int   m_w[N];
   int   m_c[N];
   int   m_last;
   int   m_rc;
   bit   m_refill;

   logic obs_gv;
   int   obs_idx;
   int   obs_rc;
   int   gcnt[N];
   int   tally;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_w[i] = 1;
         m_c[i] = 1;
      end
      m_last   = N - 1;
      m_rc     = 0;
      m_refill = 1'b0;
   endtask

   task automatic predict(output exp_t e);
      int gsel;
      int j;
      bit pend;
      int nc[N];
      e    = '0;
      gsel = -1;
      pend = 1'b0;
      if (reset) begin
         model_reset();
         return;
      end
      for (int i = 0; i < N; i++) nc[i] = m_c[i];
      if (m_refill) begin
         for (int i = 0; i < N; i++) nc[i] = m_w[i];
         if (m_rc < 65535) m_rc++;
         m_refill = 1'b0;
      end else if (!up_almFull) begin
         if (req[N-1]) begin
            gsel = N - 1;
         end else begin
            for (int k = 1; k <= N; k++) begin
               j = (m_last + k) % N;
               if (gsel < 0 && req[j] && m_c[j] > 0 && m_w[j] > 0) gsel = j;
            end
            if (gsel >= 0) begin
               nc[gsel] = nc[gsel] - 1;
               m_last   = gsel;
            end else begin
               for (int i = 0; i < N; i++) if (req[i] && m_w[i] > 0) pend = 1'b1;
               if (pend) m_refill = 1'b1;
            end
         end
      end
      if (wt_wr_en && int'(wt_wr_idx) < N) begin
         if (nc[wt_wr_idx] > int'(wt_wr_data)) nc[wt_wr_idx] = int'(wt_wr_data);
         m_w[wt_wr_idx] = int'(wt_wr_data);
      end
      for (int i = 0; i < N; i++) m_c[i] = nc[i];
      if (gsel >= 0) begin
         e.grant[gsel] = 1'b1;
         e.gv          = 1'b1;
         e.idx         = IW'(gsel);
      end
      e.rc = 16'(m_rc);
   endtask

   task automatic step();
      exp_t e;
      predict(e);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_step++;
      chk("sb_grant",       32'(grant),       32'(e.grant));
      chk("sb_grant_valid", 32'(grant_valid), 32'(e.gv));
      chk("sb_grant_idx",   32'(grant_idx),   32'(e.idx));
      chk("sb_refill_cnt",  32'(refill_cnt),  32'(e.rc));
      obs_gv  = grant_valid;
      obs_idx = int'(grant_idx);
      obs_rc  = int'(refill_cnt);
      if (grant_valid === 1'b1 && int'(grant_idx) < N) gcnt[grant_idx]++;
      $display("step %0d rst=%b req=%h alm=%b wr=%b gv=%b idx=%0d rc=%0d",
               n_step, reset, req, up_almFull, wt_wr_en, grant_valid, grant_idx, refill_cnt);
   endtask

   task automatic wr(input int idx, input int data);
      wt_wr_en   = 1'b1;
      wt_wr_idx  = IW'(idx);
      wt_wr_data = 4'(data);
      step();
      wt_wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      req        = '0;
      up_almFull = 1'b0;
      reset      = 1'b1;
      step();
      reset      = 1'b0;
   endtask

   task automatic clear_counts();
      for (int i = 0; i < N; i++) gcnt[i] = 0;
   endtask

   initial begin
      reset      = 1'b1;
      req        = '0;
      up_almFull = 1'b0;
      wt_wr_en   = 1'b0;
      wt_wr_idx  = '0;
      wt_wr_data = '0;
      model_reset();
      clear_counts();
      step();
      step();
      reset = 1'b0;
      chk("rst_grant",      32'(grant),       32'd0);
      chk("rst_refill_cnt", 32'(refill_cnt),  32'd0);

      // Weights all 1: one pass 0..7, detect cycle, refill cycle, wrap to 0.
      req = 9'h0FF;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("p1_rotation", 32'(obs_idx), 32'(i));
      end
      step();
      chk("p1_detect_idle", 32'(obs_gv), 32'd0);
      step();
      chk("p1_refill_cnt",  32'(obs_rc), 32'd1);
      step();
      chk("p1_wrap_idx",    32'(obs_idx), 32'd0);

      // Weights 3:1 between AFU0 and AFU1 over 400 cycles.
      do_reset();
      wr(0, 3);
      wr(1, 1);
      req = 9'h003;
      clear_counts();
      repeat (400) step();
      chk("p2_cnt_afu0", 32'(gcnt[0]), 32'd199);
      chk("p2_cnt_afu1", 32'(gcnt[1]), 32'd67);
      // Window edges cut one refill period, so allow one period of slack.
      chk("p2_ratio", 32'((gcnt[0] >= 3 * gcnt[1] - 3) && (gcnt[0] <= 3 * gcnt[1] + 3)), 32'd1);

      // Upstream almost-full stalls grants without touching credits.
      do_reset();
      req = 9'h0FF;
      repeat (3) step();
      up_almFull = 1'b1;
      tally = 0;
      repeat (10) begin
         step();
         if (obs_gv === 1'b0) tally++;
      end
      chk("p3_stall_cycles", 32'(tally), 32'd10);
      up_almFull = 1'b0;
      step();
      chk("p3_resume_idx", 32'(obs_idx), 32'd3);
      repeat (4) step();
      chk("p3_last_afu", 32'(obs_idx), 32'd7);
      step();
      chk("p3_detect_idle", 32'(obs_gv), 32'd0);
      up_almFull = 1'b1;
      step();
      chk("p3_refill_under_almfull", 32'(obs_rc), 32'd1);
      step();
      chk("p3_almfull_idle", 32'(obs_gv), 32'd0);
      up_almFull = 1'b0;
      step();
      chk("p3_after_refill_idx", 32'(obs_idx), 32'd0);

      // Manager priority bypasses credits and rotation.
      do_reset();
      req = 9'h0FF;
      repeat (2) step();
      req = 9'h1FF;
      tally = 0;
      repeat (5) begin
         step();
         if (obs_gv === 1'b1 && obs_idx == 8) tally++;
      end
      chk("p4_mgr_grants", 32'(tally), 32'd5);
      req = 9'h0FF;
      step();
      chk("p4_resume_idx", 32'(obs_idx), 32'd2);
      repeat (5) step();
      step();
      chk("p4_credits_kept", 32'(obs_gv), 32'd0);

      // Disabling AFU2 while it still holds credit 2.
      do_reset();
      wr(2, 3);
      req = 9'h004;
      step();
      step();
      step();
      step();
      chk("p5_afu2_before", 32'(obs_idx), 32'd2);
      req = 9'h000;
      wr(2, 0);
      req = 9'h004;
      tally = 0;
      repeat (6) begin
         step();
         if (obs_gv === 1'b0) tally++;
      end
      chk("p5_disabled_idle", 32'(tally), 32'd6);
      chk("p5_no_refill",     32'(obs_rc), 32'd1);
      req = 9'h00C;
      clear_counts();
      repeat (12) step();
      chk("p5_afu2_never", 32'(gcnt[2]), 32'd0);
      chk("p5_afu3_grants", 32'(gcnt[3]), 32'd4);

      // Reset in the middle of a grant stream.
      req = 9'h0FF;
      repeat (3) step();
      chk("p6_pre_reset_idx", 32'(obs_idx), 32'd6);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("p6_reset_grant",  32'(grant),  32'd0);
      chk("p6_reset_rc",     32'(obs_rc), 32'd0);
      step();
      chk("p6_first_idx",    32'(obs_idx), 32'd0);
      step();
      step();
      chk("p6_afu2_weight_restored", 32'(obs_idx), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
